// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive FIFO slice.
//   uart_byte_t             : one received UART byte
//   UART_FIFO_DEPTH_DEFAULT : default FIFO entry count
//   uart_cap_state_t        : capture FSM state encoding
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef logic [7:0] uart_byte_t;

    localparam int UART_FIFO_DEPTH_DEFAULT = 16;

    typedef enum logic {
        CAP_IDLE    = 1'b0,
        CAP_CAPTURE = 1'b1
    } uart_cap_state_t;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
// Bundles the receiver-side, consumer-side and status signals of the
// UART receive FIFO.
//   Receiver side : rxDone, rxData, rxErr, clear
//   Consumer side : outData, outValid, outReady
//   Status        : count, almostFull, overrun
//                   errCount, dropCount (only with UART_RX_FIFO_STATS_EN)
// Modports:
//   slave  - the FIFO itself
//   master - whatever drives the receiver inputs and consumes the bytes
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int Depth = UART_FIFO_DEPTH_DEFAULT
) ();

    localparam int PtrW = $clog2(Depth) + 1;

    logic              rxDone;
    uart_byte_t        rxData;
    logic              rxErr;
    logic              clear;
    uart_byte_t        outData;
    logic              outValid;
    logic              outReady;
    logic [PtrW-1:0]   count;
    logic              almostFull;
    logic              overrun;
`ifdef UART_RX_FIFO_STATS_EN
    logic [7:0]        errCount;
    logic [7:0]        dropCount;
`endif

    modport slave (
        input  rxDone, rxData, rxErr, clear, outReady,
        output outData, outValid, count, almostFull, overrun
`ifdef UART_RX_FIFO_STATS_EN
        , output errCount, dropCount
`endif
    );

    modport master (
        output rxDone, rxData, rxErr, clear, outReady,
        input  outData, outValid, count, almostFull, overrun
`ifdef UART_RX_FIFO_STATS_EN
        , input errCount, dropCount
`endif
    );

endinterface : uart_rx_fifo_if

// File: rtl/uart_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_fifo_mem
// FIFO storage: one synchronous write port, one asynchronous read port,
// contents are never reset.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from raddr_i)
// ---------------------------------------------------------------------------
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int Depth = UART_FIFO_DEPTH_DEFAULT,
    parameter int AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  uart_byte_t       wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output uart_byte_t       rdata_o
);

    uart_byte_t mem_q [Depth];

    // One write-decoded register per entry; the read side is a plain mux so
    // the head byte falls through without a clock of latency.
    for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (we_i && (waddr_i == AddrW'(gi))) begin
                mem_q[gi] <= wdata_i;
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive FIFO behind a UART receiver. An rxDone rising edge starts a
// one-cycle CAPTURE state in which rxData is pushed; the head byte is
// presented first-word-fallthrough to the consumer.
// Ports:
//   clk    : clock, all state updates on posedge
//   nReset : asynchronous active-low reset
//   bus    : uart_rx_fifo_if.slave (receiver inputs, consumer handshake,
//            occupancy/status outputs)
// Optional feature: define UART_RX_FIFO_STATS_EN to add the saturating
// errCount / dropCount statistics.
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int Depth      = UART_FIFO_DEPTH_DEFAULT,
    parameter int AlmostFull = 12
) (
    input  logic          clk,
    input  logic          nReset,
    uart_rx_fifo_if.slave bus
);

    localparam int AddrW = $clog2(Depth);
    localparam int PtrW  = AddrW + 1;
    // Pointers differing only in the wrap bit means the FIFO is full.
    localparam logic [PtrW-1:0] FullXor = PtrW'(Depth);

    uart_cap_state_t state_q, state_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic            overrun_q, overrun_d;
    logic            rx_done_q;
    logic            rx_err_q;

    logic            rx_done_rise;
    logic            rx_err_rise;
    logic            empty;
    logic            full;
    logic            push_req;
    logic            pop;
    logic            push_ok;
    logic            drop;
    logic            mem_we;
    logic [PtrW-1:0] occupancy;

    assign rx_done_rise = bus.rxDone & ~rx_done_q;
    assign rx_err_rise  = bus.rxErr & ~rx_err_q;

    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = ((wr_ptr_q ^ rd_ptr_q) == FullXor);

    assign push_req = (state_q == CAP_CAPTURE);
    assign pop      = ~empty & bus.outReady;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;
    assign mem_we   = push_ok & ~bus.clear;

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q   <= CAP_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
            rx_done_q <= 1'b0;
            rx_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
            rx_done_q <= bus.rxDone;
            rx_err_q  <= bus.rxErr;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        overrun_d = overrun_q;

        case (state_q)
            CAP_IDLE:    if (rx_done_rise) state_d = CAP_CAPTURE;
            CAP_CAPTURE: state_d = CAP_IDLE;
            default:     state_d = CAP_IDLE;
        endcase

        if (push_ok) wr_ptr_d  = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d  = rd_ptr_q + 1'b1;
        if (drop)    overrun_d = 1'b1;

        // Flush wins over everything, including a capture in flight.
        if (bus.clear) begin
            state_d   = CAP_IDLE;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            overrun_d = 1'b0;
        end
    end

    // ---------------- storage ----------------
    uart_fifo_mem #(
        .Depth (Depth),
        .AddrW (AddrW)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q[AddrW-1:0]),
        .wdata_i (bus.rxData),
        .raddr_i (rd_ptr_q[AddrW-1:0]),
        .rdata_o (bus.outData)
    );

    assign bus.outValid   = ~empty;
    assign bus.count      = occupancy;
    assign bus.almostFull = (occupancy >= PtrW'(AlmostFull));
    assign bus.overrun    = overrun_q;

    // ---------------- optional statistics ----------------
`ifdef UART_RX_FIFO_STATS_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        err_cnt_d  = err_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (rx_err_rise && (err_cnt_q != 8'hFF)) err_cnt_d  = err_cnt_q + 8'd1;
        if (drop && (drop_cnt_q != 8'hFF))       drop_cnt_d = drop_cnt_q + 8'd1;
        if (bus.clear) begin
            err_cnt_d  = '0;
            drop_cnt_d = '0;
        end
    end

    assign bus.errCount  = err_cnt_q;
    assign bus.dropCount = drop_cnt_q;
`else
    // Error edges only feed the statistics; without them they go nowhere.
    logic err_rise_unused;
    assign err_rise_unused = rx_err_rise;
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo (Depth=16, AlmostFull=12). Inputs are
// driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    logic clk;
    logic nReset;
    int   vectors;
    int   miscompares;

    uart_rx_fifo_if #(.Depth(16)) bus ();

    uart_rx_fifo #(
        .Depth      (16),
        .AlmostFull (12)
    ) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle rxDone pulse; returns after the CAPTURE push has happened.
    task automatic frame(input logic [7:0] b);
        @(negedge clk);
        bus.rxData = b;
        bus.rxDone = 1'b1;
        @(negedge clk);
        bus.rxDone = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk);
        bus.outReady = 1'b1;
        @(negedge clk);
        bus.outReady = 1'b0;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        nReset       = 1'b0;
        bus.rxDone   = 1'b0;
        bus.rxData   = 8'h00;
        bus.rxErr    = 1'b0;
        bus.clear    = 1'b0;
        bus.outReady = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_outValid",   bus.outValid,   0);
        check("rst_count",      bus.count,      0);
        check("rst_almostFull", bus.almostFull, 0);
        check("rst_overrun",    bus.overrun,    0);
`ifdef UART_RX_FIFO_STATS_EN
        check("rst_errCount",   bus.errCount,   0);
        check("rst_dropCount",  bus.dropCount,  0);
`endif
        nReset = 1'b1;

        // Single frame A5: capture edge, then write edge
        @(negedge clk);
        bus.rxData = 8'hA5;
        bus.rxDone = 1'b1;
        @(negedge clk);
        check("a5_not_yet_valid", bus.outValid, 0);
        bus.rxDone = 1'b0;
        @(negedge clk);
        check("a5_outValid", bus.outValid, 1);
        check("a5_outData",  bus.outData,  8'hA5);
        check("a5_count",    bus.count,    1);
        pop_one();
        check("a5_popped_count", bus.count,    0);
        check("a5_popped_valid", bus.outValid, 0);

        // rxDone held high for 20 cycles -> one entry
        @(negedge clk);
        bus.rxData = 8'h3C;
        bus.rxDone = 1'b1;
        repeat (20) @(negedge clk);
        bus.rxDone = 1'b0;
        repeat (2) @(negedge clk);
        check("held_count",   bus.count,   1);
        check("held_outData", bus.outData, 8'h3C);
        pop_one();
        check("held_popped_count", bus.count, 0);

        // 17 frames with no consumer -> full plus one drop
        for (int i = 1; i <= 17; i++) begin
            frame(8'(i));
            if (i == 11) check("af_below", bus.almostFull, 0);
            if (i == 12) check("af_at",    bus.almostFull, 1);
            if (i == 16) check("full_no_overrun_yet", bus.overrun, 0);
        end
        check("ovf_count",   bus.count,   16);
        check("ovf_overrun", bus.overrun, 1);
`ifdef UART_RX_FIFO_STATS_EN
        check("ovf_dropCount", bus.dropCount, 1);
`endif
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("ovf_pop%0d", i), bus.outData, 32'(i));
            pop_one();
        end
        check("ovf_drained_count",   bus.count,    0);
        check("ovf_drained_valid",   bus.outValid, 0);
        check("ovf_overrun_sticky",  bus.overrun,  1);

        // clear flushes overrun (and stats)
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        check("clr_overrun", bus.overrun, 0);
        check("clr_count",   bus.count,   0);
`ifdef UART_RX_FIFO_STATS_EN
        check("clr_dropCount", bus.dropCount, 0);
`endif

        // Full FIFO, pop in the same cycle as the 17th push
        for (int i = 0; i < 16; i++) frame(8'(8'h21 + i));
        check("fp_full_count", bus.count, 16);
        @(negedge clk);
        bus.rxData = 8'h40;
        bus.rxDone = 1'b1;
        @(negedge clk);
        bus.rxDone   = 1'b0;
        bus.outReady = 1'b1;
        @(negedge clk);
        bus.outReady = 1'b0;
        check("fp_count",   bus.count,   16);
        check("fp_overrun", bus.overrun, 0);
        for (int i = 0; i < 15; i++) begin
            check($sformatf("fp_pop%0d", i), bus.outData, 32'(8'h22 + i));
            pop_one();
        end
        check("fp_last_byte", bus.outData, 8'h40);
        pop_one();
        check("fp_drained", bus.count, 0);

        // clear in the same cycle as the CAPTURE push
        @(negedge clk);
        bus.rxData = 8'h77;
        bus.rxDone = 1'b1;
        @(negedge clk);
        bus.rxDone = 1'b0;
        bus.clear  = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        check("cc_count",   bus.count,    0);
        check("cc_valid",   bus.outValid, 0);
        check("cc_overrun", bus.overrun,  0);
        frame(8'h11);
        check("cc_next_count", bus.count,   1);
        check("cc_next_data",  bus.outData, 8'h11);
        pop_one();
        check("cc_next_drained", bus.count, 0);

        // Push while empty with outReady already high: push wins, pop follows
        bus.outReady = 1'b1;
        @(negedge clk);
        bus.rxData = 8'h5A;
        bus.rxDone = 1'b1;
        @(negedge clk);
        bus.rxDone = 1'b0;
        @(negedge clk);
        check("ep_count", bus.count,   1);
        check("ep_data",  bus.outData, 8'h5A);
        @(negedge clk);
        check("ep_popped", bus.count, 0);
        bus.outReady = 1'b0;

        // rxErr edges never touch the FIFO contents
        frame(8'h66);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            bus.rxErr = 1'b1;
            @(negedge clk);
            bus.rxErr = 1'b0;
`ifdef UART_RX_FIFO_STATS_EN
            if (i == 0) check("err_first", bus.errCount, 1);
`endif
        end
        @(negedge clk);
`ifdef UART_RX_FIFO_STATS_EN
        check("err_saturated", bus.errCount, 255);
`endif
        check("err_fifo_count", bus.count,   1);
        check("err_fifo_data",  bus.outData, 8'h66);

        // Asynchronous reset mid-capture loses the pending byte
        @(negedge clk);
        bus.rxData = 8'h99;
        bus.rxDone = 1'b1;
        @(negedge clk);
        bus.rxDone = 1'b0;
        #1 nReset = 1'b0;
        #1;
        check("ar_count",   bus.count,    0);
        check("ar_valid",   bus.outValid, 0);
`ifdef UART_RX_FIFO_STATS_EN
        check("ar_errCount", bus.errCount, 0);
`endif
        @(negedge clk);
        nReset = 1'b1;
        repeat (3) @(negedge clk);
        check("ar_pending_lost", bus.count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule : tb_uart_rx_fifo

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter Depth, default 16, meaning FIFO entry count; SHALL be a power of two from 2 to 256.
REQ-002 Parameter AlmostFull, default 12, meaning the count at or above which almostFull asserts; SHALL be in 1..Depth.
REQ-003 clk  input  1  clock; all state SHALL update on posedge clk.
REQ-004 nReset  input  1  reset; asynchronous, active-low.
REQ-005 rxDone  input  1  frame-complete indication from the UART receiver; may stay high for more than one cycle.
REQ-006 rxData  input  8  received byte; valid one cycle after each rxDone rising edge.
REQ-007 rxErr  input  1  receiver error strobe.
REQ-008 clear  input  1  synchronous flush.
REQ-009 outData  output  8  head-of-FIFO byte, first-word-fallthrough.
REQ-010 outValid  output  1  FIFO non-empty.
REQ-011 outReady  input  1  consumer accepts outData when outValid && outReady.
REQ-012 count  output  $clog2(Depth)+1  current occupancy.
REQ-013 almostFull  output  1  count >= AlmostFull.
REQ-014 overrun  output  1  sticky flag for a dropped byte.
REQ-015 errCount  output  8  saturating count of rxErr rising edges (only under UART_RX_FIFO_STATS_EN).
REQ-016 dropCount  output  8  saturating count of dropped bytes (only under UART_RX_FIFO_STATS_EN).

Function
REQ-017 Capture FSM SHALL have two states, IDLE and CAPTURE; IDLE->CAPTURE on an rxDone rising edge (rxDone=1, previous-cycle rxDone=0); CAPTURE->IDLE unconditionally after one cycle.
REQ-018 In CAPTURE the block SHALL push rxData, so a byte is written 2 cycles after the rxDone rising edge and is visible on outData/outValid the following cycle.
REQ-019 rxDone held high SHALL cause exactly one push; a new push requires rxDone to return low first.
REQ-020 Pop SHALL occur when outValid && outReady; outData SHALL always present mem[rdPtr]; outData is don't-care while outValid=0.
REQ-021 Pointers SHALL be $clog2(Depth)+1 bits wide with MSB-wrap full/empty detection; count = wrPtr - rdPtr, modulo pointer width.
REQ-022 Push while full with no pop SHALL drop the byte, leave memory and pointers unchanged, and set overrun.
REQ-023 Push and pop in the same cycle while full SHALL both succeed, leaving count unchanged and not setting overrun.
REQ-024 Push and pop in the same cycle while empty SHALL perform no pop, and the push SHALL succeed.
REQ-025 overrun SHALL stay set until clear or reset.
REQ-026 clear SHALL take priority over push and pop: it zeroes the pointers, clears overrun and the counters, forces the FSM to IDLE, and discards any pending capture.
REQ-027 An rxErr rising edge SHALL NOT discard or tag data; bytes are pushed regardless of rxErr.

Reset
REQ-028 nReset low SHALL immediately force: FSM=IDLE, rdPtr=wrPtr=0, outValid=0, count=0, almostFull=0, overrun=0, errCount=dropCount=0, and the rxDone/rxErr edge registers=0.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 Reset asserted mid-capture SHALL lose the pending byte.

Configuration
REQ-031 With macro UART_RX_FIFO_STATS_EN defined: errCount and dropCount ports exist; each increments by 1 per event and saturates at 255.
REQ-032 Without UART_RX_FIFO_STATS_EN: errCount and dropCount ports and their logic are absent; all other behaviour is identical.

Structure
REQ-033 Package uart_pkg SHALL hold typedef uart_byte_t (logic [7:0]) and constant UART_FIFO_DEPTH_DEFAULT = 16.
REQ-034 Storage SHALL be a sub-module uart_fifo_mem: 1 write port, asynchronous read, no reset.
REQ-035 The FSM, pointers, flags and counters SHALL reside in uart_rx_fifo.

Verification
REQ-036 Reset, then an rxDone pulse with rxData=8'hA5 -> outValid=1 and outData=8'hA5 on the 3rd cycle after the rising edge; count=1.
REQ-037 rxDone held high for 20 cycles with rxData=8'h3C -> exactly one entry; count=1.
REQ-038 17 frames with Depth=16 and outReady=0 -> count=16, overrun=1, dropCount=1; pops then return bytes 1..16 in order.
REQ-039 FIFO full with outReady=1 during the 17th push -> count stays 16, overrun=0, and the 17th byte is the last one read.
REQ-040 clear asserted in the same cycle as a CAPTURE push -> count=0, outValid=0, overrun=0; the next frame 8'h11 reads back alone.
REQ-041 300 rxErr rising edges under UART_RX_FIFO_STATS_EN -> errCount=255; FIFO contents unchanged.
